input_event_conditioner: RTL and testbench
==========================================

// Module: input_event_conditioner
// PURPOSE
//  Front end for MiniAlu's board inputs. Synchronises and debounces the four push buttons and the rotary encoder
//  (ROT_A/ROT_B/ROT_CENTER), decodes rotation direction and emits one-cycle press pulses. Serialises all events
//  into a single valid/ack event register consumed by MiniAlu's control logic.
// PARAMETERS
//  SYNC_STAGES      2       flip-flop synchroniser depth per input (>=2)
//  DEBOUNCE_CYCLES  500000  consecutive stable clocks needed to accept a level change (10 ms @ 50 MHz)
//  ROT_IDLE         1'b0    reset value of the debounced ROT_A/ROT_B levels
// PORTS
//  Clock           in   1  system clock; all logic on rising edge
//  Reset           in   1  asynchronous, active-high reset
//  BTN_EAST        in   1  raw button, active high
//  BTN_NORTH       in   1  raw button, active high
//  BTN_SOUTH       in   1  raw button, active high
//  BTN_WEST        in   1  raw button, active high
//  ROT_CENTER      in   1  raw encoder push, active high
//  ROT_A           in   1  raw encoder phase A
//  ROT_B           in   1  raw encoder phase B
//  oBtnLevel       out  5  debounced levels {CENTER,WEST,SOUTH,NORTH,EAST} (bit0=EAST)
//  oBtnPress       out  5  one-clock pulse on debounced 0->1 of each oBtnLevel bit
//  oRotCW          out  1  one-clock pulse per clockwise detent
//  oRotCCW         out  1  one-clock pulse per counter-clockwise detent
//  oEventValid     out  1  oEventCode holds an unconsumed event
//  oEventCode      out  3  1 EAST,2 NORTH,3 SOUTH,4 WEST,5 CENTER,6 CW,7 CCW; 0 when empty
//  iEventAck       in   1  consumer accepts the event; effective only while oEventValid=1
//  oEventOverflow  out  1  sticky: at least one event dropped since Reset
// BEHAVIOUR
//  Reset: every output 0; sync chains 0; debounce counters 0; button levels 0; A/B levels = ROT_IDLE; register EMPTY.
//  Reset may assert at any cycle; all state returns to the above immediately, with no pulse emitted.
//  Synchroniser: SYNC_STAGES flops per input; no logic between the stages.
//  Debounce, per input: counter clears whenever sync value == level. Counter increments while they differ.
//   When the counter reaches DEBOUNCE_CYCLES-1 and they still differ, level <= sync value at that edge and the counter clears.
//   Any glitch shorter than DEBOUNCE_CYCLES clocks produces no level change.
//  Latency, raw edge to level: SYNC_STAGES+DEBOUNCE_CYCLES clocks. oBtnPress/oRotCW/oRotCCW are asserted the cycle after the level
//   update, for exactly 1 clock. A release (1->0) produces no pulse.
//  Rotary decode: on a debounced ROT_A 0->1 edge, the current debounced ROT_B selects the direction: 0 -> oRotCW, 1 -> oRotCCW.
//   A falling edge of A and any change of B produce no pulse.
//  Event register, states EMPTY/FULL:
//   EMPTY + any pulse -> FULL; code = highest-priority pulse (CW>CCW>CENTER>EAST>NORTH>SOUTH>WEST).
//   FULL + iEventAck + no pulse -> EMPTY; code <= 0.
//   FULL + iEventAck + pulse -> stay FULL, load the new code the same cycle (no bubble).
//   FULL + no ack + pulse -> new event dropped; oEventOverflow <= 1; register unchanged.
//   Simultaneous pulses: the winner is loaded; each loser counts as a drop and sets oEventOverflow.
//   iEventAck while EMPTY is ignored. oEventOverflow clears only on Reset.
//  Counter width: $clog2(DEBOUNCE_CYCLES)+1 bits, unsigned, saturates by construction (clears on accept).
// STRUCTURE
//  Shared include boton_defs.vh: event-code localparams (EV_NONE..EV_CCW), button bit indices, priority order.
//  Sub-module debounce_filter (#(SYNC_STAGES,DEBOUNCE_CYCLES,RESET_VAL)): synchroniser, counter and stable level, plus a
//   registered rise pulse. Seven instances are used. The top level adds the direction decode, priority encoder and event register.
// TESTING (bench: DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 10 ns clock)
//  1 Reset mid-operation: assert Reset while FULL with overflow=1 -> all outputs 0 in the same cycle; no pulses after release.
//  2 Glitch reject: BTN_NORTH high for 3 clocks -> oBtnLevel/oBtnPress stay 0 and no event occurs.
//  3 Clean press: BTN_EAST high for 20 clocks -> oBtnLevel[0]=1 6 clocks after the edge; oBtnPress[0] lasts 1 clock;
//    oEventValid=1 with code=1; ack -> EMPTY, code=0; release -> no event.
//  4 Rotation: with ROT_B=0, raise ROT_A -> oRotCW pulse and code 6. With ROT_B=1, raise ROT_A -> oRotCCW and code 7.
//    A falling edge -> nothing.
//  5 Overflow: with FULL (code 1), no ack, press BTN_WEST -> code stays 1 and oEventOverflow=1, remaining set after ack.
//  6 Ack+new same cycle: hold ack high as the ROT_CENTER pulse arrives -> code 5 is loaded and oEventValid never drops.
//    Also: simultaneous CENTER+SOUTH pulses -> code 5 and overflow=1.

Source files
------------

// File: rtl/input_event_conditioner_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the MiniAlu input front end: event codes,
// raw input bit positions, event register states and the priority encoder.
package input_event_conditioner_pkg;

  localparam logic [2:0] EV_NONE   = 3'd0;
  localparam logic [2:0] EV_EAST   = 3'd1;
  localparam logic [2:0] EV_NORTH  = 3'd2;
  localparam logic [2:0] EV_SOUTH  = 3'd3;
  localparam logic [2:0] EV_WEST   = 3'd4;
  localparam logic [2:0] EV_CENTER = 3'd5;
  localparam logic [2:0] EV_CW     = 3'd6;
  localparam logic [2:0] EV_CCW    = 3'd7;

  // Bit positions inside the conditioned input vector
  localparam int IDX_EAST   = 0;
  localparam int IDX_NORTH  = 1;
  localparam int IDX_SOUTH  = 2;
  localparam int IDX_WEST   = 3;
  localparam int IDX_CENTER = 4;
  localparam int IDX_ROT_A  = 5;
  localparam int IDX_ROT_B  = 6;
  localparam int NUM_INPUTS = 7;

  typedef enum logic {
    EV_EMPTY = 1'b0,
    EV_FULL  = 1'b1
  } evState_t;

  // Pulse vector is indexed by event code; bit 0 is unused.
  // Rotation wins over the centre push, which wins over the buttons.
  function automatic logic [2:0] pickEvent(input logic [7:0] pulses);
    logic [2:0] code;
    code = EV_NONE;
    if (pulses[EV_CW])          code = EV_CW;
    else if (pulses[EV_CCW])    code = EV_CCW;
    else if (pulses[EV_CENTER]) code = EV_CENTER;
    else if (pulses[EV_EAST])   code = EV_EAST;
    else if (pulses[EV_NORTH])  code = EV_NORTH;
    else if (pulses[EV_SOUTH])  code = EV_SOUTH;
    else if (pulses[EV_WEST])   code = EV_WEST;
    return code;
  endfunction

  // Number of simultaneous pulses; anything above one means losers are dropped
  function automatic logic [3:0] countPulses(input logic [7:0] pulses);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 1; k < 8; k++) begin
      n = n + {3'd0, pulses[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/input_event_conditioner_debounce_filter.sv
`timescale 1ns/1ps
// One conditioned input: plain flop synchroniser, a stability counter that
// accepts a level change only after DEBOUNCE_CYCLES differing clocks, and a
// registered one-clock pulse the cycle after the level rises.
module debounce_filter #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_count;
  logic                   r_level;
  logic                   r_levelQ;
  logic                   r_rise;
  logic                   w_sync;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign o_level = r_level;
  assign o_rise  = r_rise;

  // Synchroniser chain: raw input shifts through SYNC_STAGES flops untouched
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  // Count clocks of disagreement; accept the new level once it has persisted
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
      r_level <= RESET_VAL;
    end else if (w_sync == r_level) begin
      r_count <= '0;
    end else if (r_count == LAST_COUNT) begin
      r_count <= '0;
      r_level <= w_sync;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  // Rise pulse one cycle after the accepted 0->1 level change
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_levelQ <= RESET_VAL;
      r_rise   <= 1'b0;
    end else begin
      r_levelQ <= r_level;
      r_rise   <= r_level & ~r_levelQ;
    end
  end

endmodule

// File: rtl/input_event_conditioner.sv
`timescale 1ns/1ps
// MiniAlu board input front end: seven debounced inputs, rotary direction
// decode and a single-entry event register with sticky overflow.
module input_event_conditioner
  import input_event_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic ROT_IDLE        = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BTN_EAST,
  input  logic       BTN_NORTH,
  input  logic       BTN_SOUTH,
  input  logic       BTN_WEST,
  input  logic       ROT_CENTER,
  input  logic       ROT_A,
  input  logic       ROT_B,
  output logic [4:0] oBtnLevel,
  output logic [4:0] oBtnPress,
  output logic       oRotCW,
  output logic       oRotCCW,
  output logic       oEventValid,
  output logic [2:0] oEventCode,
  input  logic       iEventAck,
  output logic       oEventOverflow
);

  logic [NUM_INPUTS-1:0] w_raw;
  logic [NUM_INPUTS-1:0] w_level;
  logic [NUM_INPUTS-1:0] w_rise;
  logic                  w_rotCw;
  logic                  w_rotCcw;
  logic [7:0]            w_pulses;
  logic [2:0]            w_winner;
  logic [3:0]            w_count;
  logic                  w_any;
  logic                  w_multi;

  evState_t   r_state;
  logic       r_valid;
  logic [2:0] r_code;
  logic       r_overflow;

  assign w_raw = {ROT_B, ROT_A, ROT_CENTER, BTN_WEST, BTN_SOUTH, BTN_NORTH, BTN_EAST};

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : gFilter
    debounce_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      ((g >= IDX_ROT_A) ? ROT_IDLE : 1'b0)
    ) uFilter (
      .Clock  (Clock),
      .Reset  (Reset),
      .i_raw  (w_raw[g]),
      .o_level(w_level[g]),
      .o_rise (w_rise[g])
    );
  end

  // A rising A edge is one detent; B's debounced level gives the direction
  assign w_rotCw  = w_rise[IDX_ROT_A] & ~w_level[IDX_ROT_B];
  assign w_rotCcw = w_rise[IDX_ROT_A] &  w_level[IDX_ROT_B];

  assign w_pulses = {w_rotCcw, w_rotCw, w_rise[IDX_CENTER], w_rise[IDX_WEST],
                     w_rise[IDX_SOUTH], w_rise[IDX_NORTH], w_rise[IDX_EAST], 1'b0};
  assign w_winner = pickEvent(w_pulses);
  assign w_count  = countPulses(w_pulses);
  assign w_any    = (w_count != 4'd0);
  assign w_multi  = (w_count > 4'd1);

  assign oBtnLevel      = w_level[4:0];
  assign oBtnPress      = w_rise[4:0];
  assign oRotCW         = w_rotCw;
  assign oRotCCW        = w_rotCcw;
  assign oEventValid    = r_valid;
  assign oEventCode     = r_code;
  assign oEventOverflow = r_overflow;

  // Event register: load the winning pulse when free or being acked, drop otherwise
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= EV_EMPTY;
      r_valid    <= 1'b0;
      r_code     <= EV_NONE;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        EV_EMPTY: begin
          if (w_any) begin
            r_state <= EV_FULL;
            r_valid <= 1'b1;
            r_code  <= w_winner;
            if (w_multi) r_overflow <= 1'b1;
          end
        end
        EV_FULL: begin
          if (iEventAck) begin
            if (w_any) begin
              r_code <= w_winner;
              if (w_multi) r_overflow <= 1'b1;
            end else begin
              r_state <= EV_EMPTY;
              r_valid <= 1'b0;
              r_code  <= EV_NONE;
            end
          end else if (w_any) begin
            r_overflow <= 1'b1;
          end
        end
        default: begin
          r_state <= EV_EMPTY;
          r_valid <= 1'b0;
          r_code  <= EV_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_event_conditioner.sv
`timescale 1ns/1ps
// Bench for input_event_conditioner with a short debounce window: directed
// phase table, a mid-operation reset sequence and randomized input activity,
// all compared every cycle against a window-based reference model.
module tb_input_event_conditioner;

  localparam int S   = 2;
  localparam int DEB = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [6:0] rawVec;
  logic       iEventAck;
  logic [4:0] oBtnLevel;
  logic [4:0] oBtnPress;
  logic       oRotCW;
  logic       oRotCCW;
  logic       oEventValid;
  logic [2:0] oEventCode;
  logic       oEventOverflow;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [6:0] mLvl;
  logic [6:0] mPress;
  logic [6:0] mRisePrev;
  logic       mValid;
  logic [2:0] mCode;
  logic       mOvf;
  logic [6:0] histQ[$];

  typedef struct {
    logic [6:0] raw;
    logic       ack;
    int         cycles;
    logic       doReset;
    logic [4:0] expLevel;
    logic       expValid;
    logic [2:0] expCode;
    logic       expOvf;
  } phase_t;

  phase_t phases[23];

  always #5 Clock = ~Clock;

  input_event_conditioner #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(DEB),
    .ROT_IDLE       (1'b0)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .BTN_EAST      (rawVec[0]),
    .BTN_NORTH     (rawVec[1]),
    .BTN_SOUTH     (rawVec[2]),
    .BTN_WEST      (rawVec[3]),
    .ROT_CENTER    (rawVec[4]),
    .ROT_A         (rawVec[5]),
    .ROT_B         (rawVec[6]),
    .oBtnLevel     (oBtnLevel),
    .oBtnPress     (oBtnPress),
    .oRotCW        (oRotCW),
    .oRotCCW       (oRotCCW),
    .oEventValid   (oEventValid),
    .oEventCode    (oEventCode),
    .iEventAck     (iEventAck),
    .oEventOverflow(oEventOverflow)
  );

  function automatic logic [16:0] dutBundle();
    return {oBtnLevel, oBtnPress, oRotCW, oRotCCW, oEventValid, oEventCode, oEventOverflow};
  endfunction

  function automatic logic [16:0] modelBundle();
    return {mLvl[4:0], mPress[4:0], mPress[5] & ~mLvl[6], mPress[5] & mLvl[6],
            mValid, mCode, mOvf};
  endfunction

  // Raw sample taken j edges ago (0 = this edge); before reset everything reads 0
  function automatic logic [6:0] sampleBack(int j);
    int idx;
    idx = histQ.size() - 1 - j;
    if (idx >= 0) return histQ[idx];
    return 7'd0;
  endfunction

  task automatic modelReset();
    mLvl      = 7'd0;
    mPress    = 7'd0;
    mRisePrev = 7'd0;
    mValid    = 1'b0;
    mCode     = 3'd0;
    mOvf      = 1'b0;
    histQ.delete();
  endtask

  // One clock edge of the reference model
  task automatic modelEdge(input logic [6:0] raw, input logic ack);
    int         order[7] = '{6, 7, 5, 1, 2, 3, 4};
    logic [7:0] pulses;
    logic [6:0] newRise;
    logic [6:0] smp;
    logic       allDiffer;
    int         n;
    logic [2:0] first;
    // pulses seen by the event register are those visible before this edge
    pulses = 8'd0;
    for (int i = 0; i < 5; i++) pulses[i+1] = mPress[i];
    pulses[6] = mPress[5] & ~mLvl[6];
    pulses[7] = mPress[5] &  mLvl[6];
    n = 0;
    first = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (pulses[order[k]]) begin
        if (n == 0) first = 3'(order[k]);
        n++;
      end
    end
    if (!mValid || ack) begin
      if (n > 0) begin
        mValid = 1'b1;
        mCode  = first;
        if (n > 1) mOvf = 1'b1;
      end else begin
        mValid = 1'b0;
        mCode  = 3'd0;
      end
    end else if (n > 0) begin
      mOvf = 1'b1;
    end
    // a level flips when the last DEB synchronised samples all disagree with it
    histQ.push_back(raw);
    if (histQ.size() > 16) void'(histQ.pop_front());
    newRise = 7'd0;
    for (int i = 0; i < 7; i++) begin
      allDiffer = 1'b1;
      for (int j = S; j < S + DEB; j++) begin
        smp = sampleBack(j);
        if (smp[i] == mLvl[i]) allDiffer = 1'b0;
      end
      if (allDiffer) begin
        mLvl[i] = ~mLvl[i];
        if (mLvl[i]) newRise[i] = 1'b1;
      end
    end
    mPress    = mRisePrev;
    mRisePrev = newRise;
  endtask

  task automatic checkOutput(input string name, input logic [16:0] actual, input logic [16:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, advance DUT and model, compare at the falling edge
  task automatic applyStimulus(input logic [6:0] raw, input logic ack);
    rawVec    = raw;
    iEventAck = ack;
    @(posedge Clock);
    modelEdge(raw, ack);
    @(negedge Clock);
    checkOutput("cycle model", dutBundle(), modelBundle());
  endtask

  // Asynchronous reset in the middle of a cycle, then a quiet run afterwards
  task automatic resetSequence();
    #2;
    Reset     = 1'b1;
    rawVec    = 7'd0;
    iEventAck = 1'b0;
    #1;
    checkOutput("reset async", dutBundle(), 17'd0);
    modelReset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checkOutput("reset held", dutBundle(), 17'd0);
    Reset = 1'b0;
    repeat (8) applyStimulus(7'd0, 1'b0);
    checkOutput("post reset quiet", {5'd0, oBtnPress, oRotCW, oRotCCW, oEventValid, oEventCode, oEventOverflow}, 17'd0);
  endtask

  initial begin
    logic [6:0] r;
    int         dur;

    phases[0]  = '{7'h00, 1'b0, 3,  1'b0, 5'h00, 1'b0, 3'd0, 1'b0};
    phases[1]  = '{7'h02, 1'b0, 3,  1'b0, 5'h00, 1'b0, 3'd0, 1'b0};
    phases[2]  = '{7'h00, 1'b0, 8,  1'b0, 5'h00, 1'b0, 3'd0, 1'b0};
    phases[3]  = '{7'h01, 1'b0, 10, 1'b0, 5'h01, 1'b1, 3'd1, 1'b0};
    phases[4]  = '{7'h01, 1'b1, 1,  1'b0, 5'h01, 1'b0, 3'd0, 1'b0};
    phases[5]  = '{7'h00, 1'b0, 10, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0};
    phases[6]  = '{7'h20, 1'b0, 10, 1'b0, 5'h00, 1'b1, 3'd6, 1'b0};
    phases[7]  = '{7'h20, 1'b1, 1,  1'b0, 5'h00, 1'b0, 3'd0, 1'b0};
    phases[8]  = '{7'h40, 1'b0, 10, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0};
    phases[9]  = '{7'h60, 1'b0, 10, 1'b0, 5'h00, 1'b1, 3'd7, 1'b0};
    phases[10] = '{7'h60, 1'b1, 1,  1'b0, 5'h00, 1'b0, 3'd0, 1'b0};
    phases[11] = '{7'h00, 1'b0, 10, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0};
    phases[12] = '{7'h01, 1'b0, 10, 1'b0, 5'h01, 1'b1, 3'd1, 1'b0};
    phases[13] = '{7'h09, 1'b0, 10, 1'b0, 5'h09, 1'b1, 3'd1, 1'b1};
    phases[14] = '{7'h09, 1'b1, 1,  1'b0, 5'h09, 1'b0, 3'd0, 1'b1};
    phases[15] = '{7'h00, 1'b0, 10, 1'b0, 5'h00, 1'b0, 3'd0, 1'b1};
    phases[16] = '{7'h01, 1'b0, 10, 1'b0, 5'h01, 1'b1, 3'd1, 1'b1};
    phases[17] = '{7'h01, 1'b0, 10, 1'b1, 5'h01, 1'b1, 3'd1, 1'b0};
    phases[18] = '{7'h10, 1'b0, 7,  1'b0, 5'h10, 1'b1, 3'd1, 1'b0};
    phases[19] = '{7'h10, 1'b1, 1,  1'b0, 5'h10, 1'b1, 3'd5, 1'b0};
    phases[20] = '{7'h10, 1'b1, 1,  1'b0, 5'h10, 1'b0, 3'd0, 1'b0};
    phases[21] = '{7'h00, 1'b0, 10, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0};
    phases[22] = '{7'h14, 1'b0, 10, 1'b0, 5'h14, 1'b1, 3'd5, 1'b1};

    Reset     = 1'b1;
    rawVec    = 7'd0;
    iEventAck = 1'b0;
    modelReset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checkOutput("initial reset", dutBundle(), 17'd0);
    Reset = 1'b0;

    // Hand-written latency check: level rises exactly S+DEB clocks after the raw edge
    for (int c = 1; c <= S + DEB; c++) begin
      applyStimulus(7'h01, 1'b0);
      checkOutput($sformatf("east latency c%0d", c), {12'd0, oBtnLevel}, (c == S + DEB) ? 17'd1 : 17'd0);
    end
    applyStimulus(7'h01, 1'b0);
    checkOutput("east press pulse", {12'd0, oBtnPress}, 17'd1);
    applyStimulus(7'h01, 1'b0);
    checkOutput("east press single", {12'd0, oBtnPress, oEventValid, oEventCode}, {12'd0, 5'd0, 1'b1, 3'd1});
    applyStimulus(7'h01, 1'b1);
    applyStimulus(7'h00, 1'b0);
    repeat (10) applyStimulus(7'h00, 1'b0);

    // Directed phase table
    for (int p = 0; p < 23; p++) begin
      if (phases[p].doReset) resetSequence();
      for (int c = 0; c < phases[p].cycles; c++) applyStimulus(phases[p].raw, phases[p].ack);
      checkOutput($sformatf("phase %0d", p),
                  {7'd0, oBtnLevel, oEventValid, oEventCode, oEventOverflow},
                  {7'd0, phases[p].expLevel, phases[p].expValid, phases[p].expCode, phases[p].expOvf});
    end

    // Randomized activity: sparse bit flips held for random lengths, random acks
    resetSequence();
    r = 7'd0;
    for (int seg = 0; seg < 300; seg++) begin
      r   = r ^ (7'($urandom) & 7'($urandom) & 7'($urandom));
      dur = $urandom_range(1, 10);
      for (int c = 0; c < dur; c++) applyStimulus(r, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
